core2apb_bridge: RTL



---
 rtl/core2apb_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/core2apb_bridge.sv
// Core data-side req/gnt/rvalid port to single APB3 transfers.
// One outstanding transfer; a watchdog aborts accesses to a hung slave.
module core2apb_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic                      pready_i,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pslverr_i,
    output logic                      timeout_o
);

    localparam int unsigned WCNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        WCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      to_q, to_d;
    logic [WCNT_W-1:0]         wcnt_q, wcnt_d;

    // APB3 has no strobes and addresses are word aligned.
    logic unused_in;
    assign unused_in = ^{be_i, addr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        to_d     = 1'b0;
        wcnt_d   = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    paddr_d  = {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwdata_d = wdata_i;
                    pwrite_d = we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wcnt_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    state_d = RESP;
                end else if (WDOG_EN && wcnt_q == WCNT_LAST) begin
                    rdata_d = TIMEOUT_RDATA;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            to_q     <= to_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign gnt_o     = req_i && (state_q == IDLE);
    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign rvalid_o  = (state_q == RESP);
    assign timeout_o = to_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;

endmodule
